// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} arb_state_t;
  typedef enum logic {GNT_I, GNT_D} gnt_t;

  localparam int STARVE_MAX_DEF = 4;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of data grants made while instruction fetch was kept waiting.
module mem_arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int CNT_W = cnt_width(STARVE_MAX);

  logic [CNT_W-1:0] cnt;

  assign at_max = (cnt == CNT_W'(STARVE_MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and data ports onto one single-ported memory, one
// transaction at a time, returning registered data/ack to the owner.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_ack_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              stall_o
);

  arb_state_t        state, state_n;
  gnt_t              gnt;
  logic              mem_req_n, mem_we_n, if_ack_n, d_ack_n;
  logic [ADDR_W-1:0] mem_addr_n;
  logic [DATA_W-1:0] mem_wdata_n, if_rdata_n, d_rdata_n;
  logic              inc, clr, at_max;

  mem_arb_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk    (clk_i),
    .rst    (rst_i),
    .inc    (inc),
    .clr    (clr),
    .at_max (at_max)
  );

  // Data normally wins; fetch is forced through once it has been passed over too often.
  assign gnt = (d_req_i && !(if_req_i && at_max)) ? GNT_D : GNT_I;

  always_comb begin
    state_n     = state;
    mem_req_n   = mem_req_o;
    mem_we_n    = mem_we_o;
    mem_addr_n  = mem_addr_o;
    mem_wdata_n = mem_wdata_o;
    if_rdata_n  = if_rdata_o;
    d_rdata_n   = d_rdata_o;
    if_ack_n    = 1'b0;
    d_ack_n     = 1'b0;
    inc         = 1'b0;
    clr         = 1'b0;
    case (state)
      IDLE: begin
        if (d_req_i || if_req_i) begin
          mem_req_n = 1'b1;
          if (gnt == GNT_D) begin
            state_n     = BUSY_D;
            mem_we_n    = d_we_i;
            mem_addr_n  = d_addr_i;
            mem_wdata_n = d_wdata_i;
            inc         = if_req_i;
          end else begin
            state_n    = BUSY_I;
            mem_we_n   = 1'b0;
            mem_addr_n = if_addr_i;
            clr        = 1'b1;
          end
        end
      end
      BUSY_I: begin
        if (mem_ack_i) begin
          state_n    = RESP;
          mem_req_n  = 1'b0;
          mem_we_n   = 1'b0;
          if_rdata_n = mem_rdata_i;
          if_ack_n   = 1'b1;
        end
      end
      BUSY_D: begin
        if (mem_ack_i) begin
          state_n   = RESP;
          mem_req_n = 1'b0;
          mem_we_n  = 1'b0;
          if (!mem_we_o) begin
            d_rdata_n = mem_rdata_i;
          end
          d_ack_n = 1'b1;
        end
      end
      RESP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      if_rdata_o  <= '0;
      d_rdata_o   <= '0;
      if_ack_o    <= 1'b0;
      d_ack_o     <= 1'b0;
    end else begin
      state       <= state_n;
      mem_req_o   <= mem_req_n;
      mem_we_o    <= mem_we_n;
      mem_addr_o  <= mem_addr_n;
      mem_wdata_o <= mem_wdata_n;
      if_rdata_o  <= if_rdata_n;
      d_rdata_o   <= d_rdata_n;
      if_ack_o    <= if_ack_n;
      d_ack_o     <= d_ack_n;
    end
  end

  assign stall_o = (if_req_i & ~if_ack_o) | (d_req_i & ~d_ack_o);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Transaction-level bench for mem_port_arbiter: requesters, memory and a
// grant/starvation reference model all live here.
module tb_mem_port_arbiter;

  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        if_req_i, d_req_i, d_we_i, mem_ack_i;
  logic [31:0] if_addr_i, d_addr_i, d_wdata_i, mem_rdata_i;
  logic [31:0] if_rdata_o, d_rdata_o, mem_addr_o, mem_wdata_o;
  logic        if_ack_o, d_ack_o, mem_req_o, mem_we_o, stall_o;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE_MAX)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_rdata_o(d_rdata_o), .d_ack_o(d_ack_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Requester state and reference model
  bit          if_pend, d_pend, d_w;
  logic [31:0] if_a, d_a, d_wd;
  int          starve;
  logic [31:0] exp_if_rdata, exp_d_rdata;
  logic [31:0] mem_model [logic [31:0]];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    return mem_model.exists(a) ? mem_model[a] : (a ^ 32'hA5A5_0000);
  endfunction

  task automatic drive_req();
    if_req_i  = if_pend;
    if_addr_i = if_a;
    d_req_i   = d_pend;
    d_we_i    = d_w;
    d_addr_i  = d_a;
    d_wdata_i = d_wd;
  endtask

  // One arbitration round, entered and left at posedge+1 with the DUT idle.
  task automatic round(input bit new_if, input logic [31:0] ia,
                       input bit new_d, input bit dwe, input logic [31:0] da,
                       input logic [31:0] dwd, input int wt, input bit drop,
                       input bit stale, output bit obs_d);
    bit          win_d, exp_we, wr;
    logic [31:0] exp_addr, rd;
    obs_d = 1'b0;
    if (!if_pend && new_if) begin if_pend = 1'b1; if_a = ia; end
    if (!d_pend && new_d) begin d_pend = 1'b1; d_w = dwe; d_a = da; d_wd = dwd; end
    drive_req();
    mem_ack_i   = stale;
    mem_rdata_i = $urandom;
    #1 chk("stall_idle", stall_o, if_pend | d_pend);
    @(posedge clk); #1;
    mem_ack_i = 1'b0;
    chk("ack_idle", {if_ack_o, d_ack_o}, 2'b00);
    if (!if_pend && !d_pend) begin
      chk("no_grant", mem_req_o, 1'b0);
      return;
    end
    win_d = d_pend && !(if_pend && starve == STARVE_MAX);
    if (win_d) begin
      if (if_pend) starve = (starve < STARVE_MAX) ? starve + 1 : STARVE_MAX;
    end else begin
      starve = 0;
    end
    exp_addr = win_d ? d_a : if_a;
    exp_we   = win_d ? d_w : 1'b0;
    wr       = exp_we;
    chk("gnt_req", mem_req_o, 1'b1);
    chk("gnt_addr", mem_addr_o, exp_addr);
    chk("gnt_we", mem_we_o, exp_we);
    if (wr) chk("gnt_wdata", mem_wdata_o, d_wd);
    if (drop) begin
      if (win_d) d_pend = 1'b0; else if_pend = 1'b0;
      drive_req();
    end
    #1 chk("stall_busy", stall_o, if_pend | d_pend);
    for (int i = 0; i < wt; i++) begin
      @(posedge clk); #1;
      chk("hold_req", mem_req_o, 1'b1);
      chk("hold_addr", mem_addr_o, exp_addr);
      chk("hold_we", mem_we_o, exp_we);
      if (wr) chk("hold_wdata", mem_wdata_o, d_wd);
      chk("ack_wait", {if_ack_o, d_ack_o}, 2'b00);
      chk("stall_wait", stall_o, if_pend | d_pend);
    end
    rd = wr ? $urandom : mem_read(exp_addr);
    mem_ack_i   = 1'b1;
    mem_rdata_i = rd;
    @(posedge clk); #1;
    mem_ack_i   = 1'b0;
    mem_rdata_i = $urandom;
    if (wr) mem_model[exp_addr] = d_wd;
    else if (win_d) exp_d_rdata = rd;
    else exp_if_rdata = rd;
    obs_d = d_ack_o;
    chk("if_ack", if_ack_o, !win_d);
    chk("d_ack", d_ack_o, win_d);
    chk("done_req", mem_req_o, 1'b0);
    chk("done_we", mem_we_o, 1'b0);
    chk("if_rdata", if_rdata_o, exp_if_rdata);
    chk("d_rdata", d_rdata_o, exp_d_rdata);
    chk("stall_ack", stall_o, win_d ? if_pend : d_pend);
    if (win_d) d_pend = 1'b0; else if_pend = 1'b0;
    drive_req();
    mem_ack_i = stale;
    @(posedge clk); #1;
    mem_ack_i = 1'b0;
    chk("ack_resp", {if_ack_o, d_ack_o}, 2'b00);
    chk("resp_req", mem_req_o, 1'b0);
  endtask

  int exp_ord[6] = '{1, 1, 1, 1, 0, 1};

  initial begin
    bit obs;
    rst_i = 1'b1;
    if_pend = 0; d_pend = 0; d_w = 0;
    if_a = '0; d_a = '0; d_wd = '0;
    starve = 0; exp_if_rdata = '0; exp_d_rdata = '0;
    drive_req();
    mem_ack_i = 1'b1;
    mem_rdata_i = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", mem_req_o, 1'b0);
    chk("rst_we", mem_we_o, 1'b0);
    chk("rst_addr", mem_addr_o, 32'h0);
    chk("rst_wdata", mem_wdata_o, 32'h0);
    chk("rst_rdata", {if_rdata_o, d_rdata_o}, 64'h0);
    chk("rst_ack", {if_ack_o, d_ack_o}, 2'b00);
    rst_i = 1'b0;
    @(posedge clk); #1;
    chk("stale_ack", {if_ack_o, d_ack_o}, 2'b00);
    chk("stale_req", mem_req_o, 1'b0);
    mem_ack_i = 1'b0;

    mem_model[32'h10] = 32'h2002_0005;
    round(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 0, 1'b0, 1'b0, obs);
    chk("zw_if_rdata", if_rdata_o, 32'h2002_0005);
    round(1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, 3, 1'b0, 1'b1, obs);

    for (int k = 0; k < 6; k++) begin
      round(1'b1, 32'h100 + 32'(k * 4), 1'b1, 1'b0, 32'h40, 32'h0, 0, 1'b0, 1'b0, obs);
      chk("starve_order", obs, exp_ord[k]);
    end

    round(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2, 1'b1, 1'b1, obs);

    // Reset while a data write is in flight
    d_pend = 1'b1; d_w = 1'b1; d_a = 32'h80; d_wd = $urandom;
    drive_req();
    @(posedge clk); #1;
    chk("pre_rst_req", mem_req_o, 1'b1);
    #2 rst_i = 1'b1;
    #1;
    chk("mid_rst_req", mem_req_o, 1'b0);
    chk("mid_rst_we", mem_we_o, 1'b0);
    chk("mid_rst_addr", mem_addr_o, 32'h0);
    chk("mid_rst_wdata", mem_wdata_o, 32'h0);
    chk("mid_rst_rdata", {if_rdata_o, d_rdata_o}, 64'h0);
    d_pend = 1'b0; if_pend = 1'b0; starve = 0;
    exp_if_rdata = '0; exp_d_rdata = '0;
    drive_req();
    @(posedge clk); #1;
    rst_i = 1'b0;
    mem_ack_i = 1'b1;
    @(posedge clk); #1;
    mem_ack_i = 1'b0;
    chk("post_rst_ack", {if_ack_o, d_ack_o}, 2'b00);
    chk("post_rst_req", mem_req_o, 1'b0);

    for (int n = 0; n < 250; n++) begin
      round($urandom_range(0, 3) != 0, {26'h0, 4'($urandom_range(0, 15)), 2'b00},
            $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            {26'h0, 4'($urandom_range(0, 15)), 2'b00}, $urandom,
            $urandom_range(0, 3), $urandom_range(0, 9) == 0,
            $urandom_range(0, 1) == 1, obs);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the pipeline's instruction-fetch port (IF) and data port (MEM stage).
- Grants one transaction at a time and tracks it to completion.
- Returns read data and an ack pulse to the owning requester, and drives a pipeline stall while any request is pending.
- Sits between the PC/IF/ID front end, the EX/MEM stage and the external memory model.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive data grants made while IF waits before IF is forced to win (>=1)

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- if_req_i  in  1  fetch request; held with if_addr_i until if_ack_o
- if_addr_i  in  ADDR_W  fetch address
- if_rdata_o  out  DATA_W  fetched instruction, valid while if_ack_o=1
- if_ack_o  out  1  one-cycle fetch completion pulse
- d_req_i  in  1  data request; held with d_we_i/d_addr_i/d_wdata_i until d_ack_o
- d_we_i  in  1  1=write, 0=read
- d_addr_i  in  ADDR_W  data address
- d_wdata_i  in  DATA_W  write data
- d_rdata_o  out  DATA_W  read data, valid while d_ack_o=1
- d_ack_o  out  1  one-cycle data completion pulse
- mem_req_o  out  1  memory request, level; held until mem_ack_i
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_rdata_i  in  DATA_W  memory read data, valid with mem_ack_i
- mem_ack_i  in  1  memory completion, may assert in the same cycle as mem_req_o
- stall_o  out  1  pipeline stall

Behaviour:
- Clock and reset: one clock clk_i. rst_i is asynchronous and active-high.
- Reset values: state=IDLE; all acks, mem_req_o and mem_we_o = 0; mem_addr_o, mem_wdata_o, if_rdata_o, d_rdata_o = 0; starve_cnt=0.
- States: IDLE, BUSY_I, BUSY_D, RESP. All outputs except stall_o are registered.
- IDLE, arbitration:
  - d_req_i only -> BUSY_D.
  - if_req_i only -> BUSY_I.
  - Both -> BUSY_D, unless starve_cnt==STARVE_MAX, then BUSY_I.
  - Neither -> stay in IDLE.
  - On entry to BUSY_x, register mem_req_o=1 together with the granted requester's addr/we/wdata. IF is always a read (mem_we_o=0).
- BUSY_x: hold mem_* stable. When mem_ack_i=1:
  - drop mem_req_o and mem_we_o;
  - capture mem_rdata_i into x_rdata_o (reads only; d_rdata_o is unchanged on writes);
  - set x_ack_o=1 for exactly one cycle;
  - go to RESP.
- RESP: acks clear, then go to IDLE. No grant is made in RESP, so the requester has the ack cycle to advance or drop its request.
- Throughput: minimum 3 cycles per access (grant edge, ack edge, RESP). Latency from request to ack = 2 + memory wait cycles.
- starve_cnt:
  - +1, saturating at STARVE_MAX, on each grant to D while if_req_i=1.
  - Cleared on each grant to IF.
  - Unchanged otherwise.
- stall_o is combinational: (if_req_i & ~if_ack_o) | (d_req_i & ~d_ack_o).
- Boundary conditions:
  - mem_ack_i in IDLE or RESP is ignored, including a stale ack after reset.
  - A requester that drops its request mid-BUSY does not abort the transaction. The ack still pulses and is ignored by the pipeline.
  - Reset mid-transaction returns to IDLE immediately. No ack is issued for the aborted access.
  - mem_ack_i in the first BUSY cycle is legal, giving zero-wait operation.

Decomposition:
- Shared package mem_arb_pkg: state enum {IDLE, BUSY_I, BUSY_D, RESP}, grant encoding {GNT_I, GNT_D}, default STARVE_MAX.
- One sub-module: mem_arb_starve_ctr, a saturating counter with inc/clr inputs and an at_max output.
- The FSM, output registers and muxing stay in mem_port_arbiter.

Test Plan:
- Zero-wait IF read: if_req_i=1, if_addr_i=0x0000_0010, memory acks with 0x2002_0005 in the first BUSY cycle -> mem_addr_o=0x10 one cycle after the request; if_ack_o pulses 2 cycles after the request with if_rdata_o=0x2002_0005; stall_o=1 until the ack cycle.
- Data write with 3 wait cycles: d_req_i=1, d_we_i=1, addr 0x40, wdata 0xDEAD_BEEF -> mem_we_o=1 and mem_wdata_o=0xDEADBEEF held 4 cycles; d_ack_o is a single pulse; d_rdata_o is unchanged.
- Simultaneous requests: both held continuously, zero-wait memory, STARVE_MAX=4 -> grant order D,D,D,D,I,D,...; starve_cnt reads 4 at the forced IF grant, then 0.
- Stale and out-of-state ack: pulse mem_ack_i=1 while in IDLE and in RESP -> no ack output, no state change.
- Reset mid-operation: assert rst_i asynchronously in BUSY_D, then mem_ack_i arrives after release -> outputs zero immediately, no d_ack_o, state IDLE, next request served normally.
- Drop mid-BUSY: if_req_i deasserted after grant -> transaction completes, if_ack_o still pulses once, stall_o=0 throughout the drop.
